// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths (bit timing, frame shape, TX states).
// Build option UART_TX_PARITY_EN adds the even-parity state to the TX FSM.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int DATA_BITS            = 8;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START_BIT  = 3'd1,
        ST_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY_BIT = 3'd3,
`endif
        ST_STOP_BIT   = 3'd4,
        ST_CLEANUP    = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request / serial-status bundle between an on-chip producer (master) and uart_tx (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic                 tx_dv;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx_serial;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        output tx_dv, tx_byte,
        input  tx_serial, tx_active, tx_done
    );

    modport slave (
        input  tx_dv, tx_byte,
        output tx_serial, tx_active, tx_done
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_end is high in the last clock of each CLKS_PER_BIT-cycle bit.
// Latency: bit_end decodes a register; clear holds the count at zero. No backpressure.
// Backpressure: none; the count runs freely whenever clear is low.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Self-clears at the terminal count so it never wraps through unused codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (count == TERMINAL)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_end = (count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (even parity bit added when UART_TX_PARITY_EN is defined).
// Latency: accept in IDLE at cycle N drives the start bit from N+1; all outputs registered.
// Backpressure: requests are taken only in IDLE; tx_dv while busy or in CLEANUP is dropped.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    uart_tx_state_t         state, state_nxt;
    logic [BIT_IDX_W-1:0]   idx, idx_nxt;
    logic [DATA_BITS-1:0]   data_q, data_nxt;
    logic                   serial_q, serial_nxt;
    logic                   active_q, active_nxt;
    logic                   done_q, done_nxt;
    logic                   bit_end;
    logic                   cnt_clear;

    // The bit timer only runs while a bit is on the line.
    assign cnt_clear = (state == ST_IDLE) || (state == ST_CLEANUP);

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            data_q   <= data_nxt;
            serial_q <= serial_nxt;
            active_q <= active_nxt;
            done_q   <= done_nxt;
        end
    end

    // Next-state logic also computes the next line level so tx_serial comes straight from a flop.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        data_nxt   = data_q;
        serial_nxt = serial_q;
        active_nxt = active_q;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                serial_nxt = 1'b1;
                active_nxt = 1'b0;
                if (bus.tx_dv) begin
                    data_nxt   = bus.tx_byte;
                    idx_nxt    = '0;
                    state_nxt  = ST_START_BIT;
                    serial_nxt = 1'b0;
                    active_nxt = 1'b1;
                end
            end
            ST_START_BIT: begin
                if (bit_end) begin
                    state_nxt  = ST_DATA_BITS;
                    idx_nxt    = '0;
                    serial_nxt = data_q[0];
                end
            end
            ST_DATA_BITS: begin
                if (bit_end) begin
                    if (idx == LAST_BIT_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt  = ST_PARITY_BIT;
                        serial_nxt = ^data_q;
`else
                        state_nxt  = ST_STOP_BIT;
                        serial_nxt = 1'b1;
`endif
                    end else begin
                        idx_nxt    = idx + BIT_IDX_W'(1);
                        serial_nxt = data_q[idx_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY_BIT: begin
                if (bit_end) begin
                    state_nxt  = ST_STOP_BIT;
                    serial_nxt = 1'b1;
                end
            end
`endif
            ST_STOP_BIT: begin
                if (bit_end) begin
                    state_nxt  = ST_CLEANUP;
                    serial_nxt = 1'b1;
                    active_nxt = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
            ST_CLEANUP: begin
                state_nxt  = ST_IDLE;
                serial_nxt = 1'b1;
                active_nxt = 1'b0;
            end
            default: begin
                state_nxt  = ST_IDLE;
                serial_nxt = 1'b1;
                active_nxt = 1'b0;
            end
        endcase
    end

    assign bus.tx_serial = serial_q;
    assign bus.tx_active = active_q;
    assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; outputs sampled on the falling edge.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   first_start = 0;

    uart_tx_if bus();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Line levels of one frame, index 0 = start bit.
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
        logic [NB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Present b in IDLE for one accept edge; afterwards scribble tx_byte to prove it was latched.
    task automatic send(input logic [7:0] b);
        check("idle_serial_before_accept", 32'(bus.tx_serial), 32'd1);
        check("idle_active_before_accept", 32'(bus.tx_active), 32'd0);
        bus.tx_dv   = 1'b1;
        bus.tx_byte = b;
        @(negedge clk);
        bus.tx_dv   = 1'b0;
        bus.tx_byte = ~b;
    endtask

    // Called at the falling edge of the first start-bit cycle; returns at the idle cycle after CLEANUP.
    task automatic expect_frame(input logic [7:0] b, input int pulse_k,
                                input logic [7:0] pulse_byte, input int off_k);
        logic [NB-1:0] f;
        f = frame_bits(b);
        last_start = cyc;
        for (int k = 0; k < NB*CPB; k++) begin
            check($sformatf("serial_%02h_k%0d", b, k), 32'(bus.tx_serial), 32'(f[k/CPB]));
            check($sformatf("active_%02h_k%0d", b, k), 32'(bus.tx_active), 32'd1);
            check($sformatf("done_low_%02h_k%0d", b, k), 32'(bus.tx_done), 32'd0);
            if (k == pulse_k) begin
                bus.tx_dv   = 1'b1;
                bus.tx_byte = pulse_byte;
            end
            if (k == off_k) bus.tx_dv = 1'b0;
            @(negedge clk);
        end
        check($sformatf("cleanup_done_%02h", b), 32'(bus.tx_done), 32'd1);
        check($sformatf("cleanup_active_%02h", b), 32'(bus.tx_active), 32'd0);
        check($sformatf("cleanup_serial_%02h", b), 32'(bus.tx_serial), 32'd1);
        @(negedge clk);
        check($sformatf("post_done_low_%02h", b), 32'(bus.tx_done), 32'd0);
    endtask

    initial begin
        logic [NB-1:0] f81;
        bus.tx_dv   = 1'b0;
        bus.tx_byte = 8'h00;

        // Reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_serial", 32'(bus.tx_serial), 32'd1);
        check("reset_active", 32'(bus.tx_active), 32'd0);
        check("reset_done",   32'(bus.tx_done),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain frame: 0,1,0,1,0,0,1,0,1,1 (parity 0 inserted before stop when enabled).
        send(8'hA5);
        expect_frame(8'hA5, -1, 8'h00, -1);

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        expect_frame(8'h07, -1, 8'h00, -1);
`endif

        // A one-cycle request in the middle of data bit 3 must be dropped.
        send(8'h55);
        expect_frame(8'h55, 17, 8'h3C, 18);
        for (int i = 0; i < 3; i++) begin
            check("no_frame_for_3c_serial", 32'(bus.tx_serial), 32'd1);
            check("no_frame_for_3c_active", 32'(bus.tx_active), 32'd0);
            @(negedge clk);
        end

        // tx_dv held high: second frame starts right after CLEANUP plus one IDLE cycle.
        bus.tx_dv   = 1'b1;
        bus.tx_byte = 8'h00;
        @(negedge clk);
        bus.tx_byte = 8'hFF;
        expect_frame(8'h00, -1, 8'h00, -1);
        first_start = last_start;
        check("gap_serial_high", 32'(bus.tx_serial), 32'd1);
        check("gap_active_low",  32'(bus.tx_active), 32'd0);
        @(negedge clk);
        expect_frame(8'hFF, -1, 8'h00, 5);
        check("accept_to_accept", 32'(last_start - first_start), 32'(NB*CPB + 2));

        // Reset in the middle of data bit 3 (a zero bit) of 0x81.
        f81 = frame_bits(8'h81);
        send(8'h81);
        for (int k = 0; k < 17; k++) begin
            check($sformatf("abort_serial_k%0d", k), 32'(bus.tx_serial), 32'(f81[k/CPB]));
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("abort_serial_high", 32'(bus.tx_serial), 32'd1);
        check("abort_active_low",  32'(bus.tx_active), 32'd0);
        check("abort_done_low",    32'(bus.tx_done),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.tx_done), 32'd0);
            check("abort_idle_serial", 32'(bus.tx_serial), 32'd1);
        end
        send(8'h81);
        expect_frame(8'h81, -1, 8'h00, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
